// File: rtl/top_tx_prod_accum_if.sv
// Handshake bundle between the TX gain multiplier, the block accumulator
// and the TX framer.
//   din/din_vld/din_rdy        product stream into the accumulator
//   dout/dout_sat/dout_vld/dout_rdy  saturated block sum out of the accumulator
// Modports:
//   slave  - the accumulator (consumes din, produces dout)
//   master - the surrounding logic (produces din, consumes dout)
interface top_tx_prod_accum_if #(
   parameter int DIN_WIDTH  = 13,
   parameter int DOUT_WIDTH = 16
) ();
   logic [DIN_WIDTH-1:0]  din;
   logic                  din_vld;
   logic                  din_rdy;
   logic [DOUT_WIDTH-1:0] dout;
   logic                  dout_sat;
   logic                  dout_vld;
   logic                  dout_rdy;

   modport slave (
      input  din, din_vld, dout_rdy,
      output din_rdy, dout, dout_sat, dout_vld
   );

   modport master (
      output din, din_vld, dout_rdy,
      input  din_rdy, dout, dout_sat, dout_vld
   );
endinterface

// File: rtl/top_tx_prod_accum.sv
// Block accumulator behind the TX gain multiplier. Sums each block of
// BLOCK_LEN unsigned products and presents the sum, saturated to DOUT_WIDTH
// bits, on a registered valid/ready output for the TX framer.
// Ports:
//   ap_clk    clock, rising edge
//   ap_rst_n  asynchronous active-low reset
//   clr       synchronous clear of the partial block (output reg untouched)
//   bus       slave side of top_tx_prod_accum_if (din stream in, dout out)
//   busy      registered, high while a partial block is in progress
module top_tx_prod_accum #(
   parameter int DIN_WIDTH  = 13,
   parameter int BLOCK_LEN  = 16,
   parameter int CNT_WIDTH  = 5,
   parameter int ACC_WIDTH  = 17,
   parameter int DOUT_WIDTH = 16
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                clr,
   top_tx_prod_accum_if.slave  bus,
   output logic                busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_STALL = 2'd2;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN - 1);
   localparam logic [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'({DOUT_WIDTH{1'b1}});

   logic [1:0]            state_reg, state_next;
   logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
   logic [ACC_WIDTH-1:0]  acc_reg, acc_next;
   logic [DOUT_WIDTH-1:0] dout_reg;
   logic                  dout_sat_reg;
   logic                  dout_vld_reg;
   logic                  busy_reg;

   logic [ACC_WIDTH-1:0]  sum;
   logic [DOUT_WIDTH-1:0] clip;
   logic                  sat;
   logic                  is_last;
   logic                  accept;
   logic                  drain;
   logic                  final_accept;

   assign is_last = (cnt_reg == LAST_CNT);

   // Only the final beat is held back by an undrained sum; earlier beats
   // keep flowing. Forced low while reset is asserted.
   assign bus.din_rdy = ap_rst_n & ~(is_last & dout_vld_reg & ~bus.dout_rdy);

   assign accept       = bus.din_vld & bus.din_rdy;
   assign drain        = dout_vld_reg & bus.dout_rdy;
   // A final beat that coincides with clr is discarded, so no sum is emitted.
   assign final_accept = accept & is_last & ~clr;

   assign sum = acc_reg + ACC_WIDTH'(bus.din);
   assign sat = (sum > SAT_MAX);

   // Saturation: every output bit forced high when the sum is clipped.
   generate
      for (genvar gi = 0; gi < DOUT_WIDTH; gi++) begin : g_clip
         assign clip[gi] = sat | sum[gi];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      acc_next   = acc_reg;
      if (clr) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
         acc_next   = '0;
      end else if (accept) begin
         if (is_last) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            acc_next   = '0;
         end else begin
            state_next = ST_ACCUM;
            cnt_next   = cnt_reg + CNT_WIDTH'(1);
            acc_next   = sum;
         end
      end else if (is_last & bus.din_vld & dout_vld_reg & ~bus.dout_rdy) begin
         state_next = ST_STALL;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         acc_reg      <= '0;
         dout_reg     <= '0;
         dout_sat_reg <= 1'b0;
         dout_vld_reg <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         acc_reg   <= acc_next;
         busy_reg  <= (cnt_next != '0);
         // A new sum takes priority over a drain in the same cycle, which
         // keeps dout_vld high for back-to-back blocks.
         if (final_accept) begin
            dout_reg     <= clip;
            dout_sat_reg <= sat;
            dout_vld_reg <= 1'b1;
         end else if (drain) begin
            dout_vld_reg <= 1'b0;
         end
      end
   end

   assign bus.dout     = dout_reg;
   assign bus.dout_sat = dout_sat_reg;
   assign bus.dout_vld = dout_vld_reg;
   assign busy         = busy_reg;

endmodule
